// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler that shares one bin2bcd converter among four requesters.
// Each conversion is saturated to MAXVAL and abandoned after TIMEOUT cycles without a done.
module bcd_conv_sched #(
  parameter int TIMEOUT = 64,
  parameter int MAXVAL  = 9999
) (
  input  logic        clk100Mhz,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [55:0] req_bin,
  output logic        conv_start,
  output logic [13:0] conv_bin,
  input  logic        conv_done,
  input  logic [15:0] conv_bcd,
  output logic [3:0]  gnt,
  output logic [15:0] result_bcd,
  output logic [1:0]  result_id,
  output logic        result_valid,
  output logic        ovf,
  output logic        err_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_reg;
  logic [1:0]    ptr_reg;
  logic [1:0]    id_reg;
  logic [1:0]    result_id_reg;
  logic [CW-1:0] cnt_reg;
  logic [13:0]   conv_bin_reg;
  logic [15:0]   result_bcd_reg;
  logic          ovf_flag_reg;
  logic          err_flag_reg;

  logic [13:0] bin_arr [4];
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand_idx;
  logic [13:0] sel_bin;
  logic        sat_ovf;
  logic [13:0] sat_bin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign bin_arr[gi] = req_bin[14*gi +: 14];
    end
  endgenerate

  // Scan from ptr+4 (ptr itself, lowest priority) down to ptr+1 so the
  // nearest requester after ptr overwrites any farther one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand_idx  = ptr_reg;
    for (int k = 4; k >= 1; k--) begin
      cand_idx = ptr_reg + 2'(k);
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign sel_bin = bin_arr[win_idx];
  assign sat_ovf = (sel_bin > 14'(MAXVAL));
  assign sat_bin = sat_ovf ? 14'(MAXVAL) : sel_bin;

  always_ff @(posedge clk100Mhz) begin
    if (!rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= 2'd3;
      id_reg         <= 2'd0;
      result_id_reg  <= 2'd0;
      cnt_reg        <= '0;
      conv_bin_reg   <= '0;
      result_bcd_reg <= 16'h0000;
      ovf_flag_reg   <= 1'b0;
      err_flag_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            id_reg       <= win_idx;
            ptr_reg      <= win_idx;
            conv_bin_reg <= sat_bin;
            ovf_flag_reg <= sat_ovf;
            err_flag_reg <= 1'b0;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A done in the final timeout cycle still counts as a good conversion.
          if (conv_done) begin
            result_bcd_reg <= conv_bcd;
            result_id_reg  <= id_reg;
            state_reg      <= DELIVER;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            result_bcd_reg <= 16'hFFFF;
            result_id_reg  <= id_reg;
            err_flag_reg   <= 1'b1;
            state_reg      <= DELIVER;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign conv_start   = (state_reg == ISSUE);
  assign conv_bin     = conv_bin_reg;
  assign result_valid = (state_reg == DELIVER);
  assign gnt          = result_valid ? (4'b0001 << id_reg) : 4'b0000;
  assign result_bcd   = result_bcd_reg;
  assign result_id    = result_id_reg;
  assign ovf          = result_valid & ovf_flag_reg;
  assign err_timeout  = result_valid & err_flag_reg;

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles spent in WAIT before the conversion is abandoned.
REQ-002 Parameter: MAXVAL, 9999, largest value the 4-digit converter accepts.
REQ-003 clk100Mhz  input  1  single system clock; all logic rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk100Mhz.
REQ-005 req  input  4  per-requester conversion request, level, held until that requester's gnt bit pulses.
REQ-006 req_bin  input  56  requester i value in bits [14i+13:14i], unsigned.
REQ-007 conv_start  output  1  one-cycle start pulse to the shared bin2bcd converter.
REQ-008 conv_bin  output  14  operand to the converter, stable from conv_start until conv_done.
REQ-009 conv_done  input  1  one-cycle pulse from the converter; conv_bcd is valid in the same cycle.
REQ-010 conv_bcd  input  16  converter result, 4 BCD digits, thousands in [15:12].
REQ-011 gnt  output  4  one-hot, one-cycle pulse marking delivery to the selected requester.
REQ-012 result_bcd  output  16  delivered BCD value, held until the next delivery.
REQ-013 result_id  output  2  index of the requester served, held with result_bcd.
REQ-014 result_valid  output  1  one-cycle pulse, coincident with gnt.
REQ-015 ovf  output  1  high with result_valid when the operand was saturated.
REQ-016 err_timeout  output  1  high with result_valid when the conversion timed out.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DELIVER, with no other reachable state.
REQ-018 IDLE: if any req bit is high, the block selects the winner round-robin starting at index ptr+1 mod 4, latches the winner index and its req_bin, and moves to ISSUE; otherwise it stays in IDLE.
REQ-019 ptr updates to the winner index at the moment of selection, giving fairness among requesters that are high at the same time.
REQ-020 Saturation: a latched value greater than MAXVAL is replaced by MAXVAL and sets an internal ovf flag; values 0..MAXVAL pass through unchanged.
REQ-021 ISSUE: conv_start=1 for exactly one cycle with conv_bin = the saturated operand; the next state is WAIT with the timeout counter at 0.
REQ-022 WAIT: conv_bin is held; the counter increments every cycle.
REQ-023 WAIT exit on done: when conv_done=1, conv_bcd is captured into result_bcd and the next state is DELIVER.
REQ-024 WAIT exit on timeout: when the counter reaches TIMEOUT-1 without conv_done, result_bcd becomes 16'hFFFF, the internal error flag is set and the next state is DELIVER.
REQ-025 If conv_done and the timeout occur in the same cycle, conv_done wins and no error is flagged.
REQ-026 DELIVER: for one cycle, result_valid=1, gnt[id]=1, result_id=id, and ovf and err_timeout reflect the flags; the next state is IDLE.
REQ-027 conv_done pulses arriving in IDLE, ISSUE or DELIVER are ignored.
REQ-028 Latency: req rising in IDLE at cycle 0 gives conv_start at cycle 1, and result_valid one cycle after conv_done.
REQ-029 The minimum gap between two result_valid pulses is 3 cycles plus the converter latency.
REQ-030 A req bit that drops before its grant is treated as a withdrawal: its result is still delivered if its conversion was already issued.
REQ-031 Changes to req_bin after latching have no effect on the operand in flight.

Reset
REQ-032 When rst=0, on the clock edge the state goes to IDLE and ptr is set to 3, so index 0 has first priority.
REQ-033 Reset clears the counter and all flags.
REQ-034 Reset drives conv_start, gnt, result_valid, ovf and err_timeout to 0, conv_bin to 0, result_bcd to 16'h0000 and result_id to 0.
REQ-035 Reset asserted mid-conversion abandons the conversion with no delivery; a late conv_done after reset is ignored.

Verification
REQ-036 Single request: req=4'b0010, requester 1 value = 7850, converter done after 16 cycles -> conv_start at cycle 1, conv_bin=7850, then result_valid with gnt=4'b0010, result_bcd=16'h7850, result_id=1.
REQ-037 Contention: all req high from reset release -> grant order 0,1,2,3,0 with each gnt a single-cycle pulse.
REQ-038 Saturation: requester 2 value = 12000 -> conv_bin=9999 and ovf=1 at delivery; value 12 -> result_bcd=16'h0012 with ovf=0.
REQ-039 Timeout: converter never asserts conv_done, TIMEOUT=64 -> result_valid 64 cycles after WAIT entry, result_bcd=16'hFFFF, err_timeout=1; the next request then proceeds normally.
REQ-040 Edge cases: conv_done coincident with the last timeout cycle -> no error and the converter data is delivered.
REQ-041 Reset during WAIT -> no gnt; a subsequent stray conv_done produces no result_valid.
